zint_ctrl: RTL and testbench
============================

// Module: zint_ctrl
// PURPOSE
//  Parametrised ZX-bus interrupt controller for NUM_SRC chip interrupt lines (W5300, SL811, future).
//  Replaces the fixed two-source AND/OR in the top level.
//  Adds sync, polarity, per-source level/edge mode, pending latches, W1C clear and priority ID.
//  Driven by the ports register decode; int_req feeds the open-drain zint_n driver in top.
// PARAMETERS
//  NUM_SRC   4        number of sources, 1..8
//  SRC_POL   8'h01    per-source active level: bit=1 active-low (w5300_int_n), bit=0 active-high
//  PULSE_LEN 32       int_req pulse width in clk cycles (pulse mode only), >=1
//  HOLD_LEN  64       min gap between pulses in clk cycles (pulse mode only), >=1
// PORTS
//  clk      in   1        system clock
//  rst      in   1        synchronous, active-high reset
//  src      in   NUM_SRC  raw async interrupt inputs
//  wr_stb   in   1        one-cycle register write strobe
//  addr     in   2        register select
//  wrdata   in   8        write data
//  rddata   out  8        read data, combinational on addr
//  int_req  out  1        1 = pull zint_n low
//  int_id   out  3        index of highest-priority pending+enabled source
// BEHAVIOUR
//  - Inputs: 2-flop sync per source, then XOR with SRC_POL -> act[i]; 2-cycle latency to act.
//  - Regs (bits >= NUM_SRC read 0, writes ignored):
//    0 ENA  RW mask; reset 0
//    1 MODE RW per source; 1=edge, 0=level; reset 0
//    2 PEND R: pending bits; W: write-1-to-clear (edge sources only)
//    3 CTRL W bit7=gena; R bit7=gena, bit6=any, bits2:0=int_id; reset 0
//  - Level source: pend[i] = act[i] every cycle; W1C has no effect.
//  - Edge source: pend[i] set on act 0->1 (registered prev); held until W1C.
//    Set and W1C in the same cycle -> set wins (bit stays 1).
//  - MODE write edge->level: pend follows act next cycle. Level->edge: pend cleared unless edge same cycle.
//  - Pend updates regardless of ENA; masking applies only at request stage.
//  - req = gena & |(pend & ENA); int_id = lowest index with pend&ENA; 0 when none.
//  - Reset: ENA=0, MODE=0, gena=0, pend=0, sync flops=0, int_req=0, int_id=0, FSM=IDLE.
//  - rst mid-pulse aborts immediately; int_req=0 on the next edge.
// CONFIGURATION
//  ZINT_PULSE_EN defined: int_req is pulse-shaped by a 3-state FSM.
//    IDLE   : req=1 -> ASSERT, load cnt=PULSE_LEN-1; int_req=1 from next cycle.
//    ASSERT : int_req=1; cnt=0 -> HOLD, cnt=HOLD_LEN-1; req dropping does not shorten the pulse.
//    HOLD   : int_req=0; cnt=0 -> IDLE; re-pulses if req still 1.
//    Pulse = exactly PULSE_LEN cycles; gap >= HOLD_LEN cycles.
//    Counter width = clog2(max(PULSE_LEN,HOLD_LEN)).
//  ZINT_PULSE_EN undefined: int_req = req registered (1-cycle delay); no FSM or counters.
// TESTING
//  1 Reset: rst=1 for 2 clk with src toggling -> int_req=0, rddata=0 for all addr.
//  2 Level: ENA=01, CTRL=80, drive src[0] low (SRC_POL bit0) ->
//    int_req=1 after 3 clk; src[0] high -> int_req=0 after 3 clk.
//  3 Edge+W1C: MODE=02, ENA=02, CTRL=80; pulse src[1] for 1 clk ->
//    PEND=02 and int_req held; write PEND=02 -> int_req=0.
//  4 Set/clear collision: W1C to PEND bit1 on the same cycle as a src[1] rising edge -> PEND reads 02.
//  5 Priority: pend=0C, ENA=0F -> int_id=2, CTRL reads C2; clear bit2 -> int_id=3.
//  6 ZINT_PULSE_EN: level source held active ->
//    int_req high exactly 32 clk, low exactly 64 clk, repeating; rst mid-pulse -> low next clk.

Source files
------------

// File: rtl/zint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : zint_ctrl
//  Brief    : ZX-bus interrupt controller. Synchronises NUM_SRC interrupt lines,
//             applies polarity and level/edge modes, and keeps W1C pending
//             latches. It produces an enable-masked request and the
//             lowest-index pending source ID. When ZINT_PULSE_EN is defined,
//             int_req is pulse-shaped; otherwise it is the request delayed
//             by one register.
//  Revision : 1.0 - initial release
// ============================================================================
module zint_ctrl #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] SRC_POL   = 8'h01,
    parameter int         PULSE_LEN = 32,
    parameter int         HOLD_LEN  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               wr_stb,
    input  logic [1:0]         addr,
    input  logic [7:0]         wrdata,
    output logic [7:0]         rddata,
    output logic               int_req,
    output logic [2:0]         int_id
);

    localparam logic [1:0] c_ADDR_ENA  = 2'd0;
    localparam logic [1:0] c_ADDR_MODE = 2'd1;
    localparam logic [1:0] c_ADDR_PEND = 2'd2;
    localparam logic [1:0] c_ADDR_CTRL = 2'd3;

    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_act_prev;
    logic [NUM_SRC-1:0] r_ena;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_pend_edge;
    logic               r_gena;
    logic               r_int_req;

    logic [NUM_SRC-1:0] w_act;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_mode_nxt;
    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_hit;
    logic               w_any;
    logic               w_req;
    logic [2:0]         w_id;
    logic [7:0]         w_rd;
    logic               w_wr_ena;
    logic               w_wr_mode;
    logic               w_wr_pend;
    logic               w_wr_ctrl;
    logic               w_unused_wrdata;

    assign w_wr_ena  = wr_stb && (addr == c_ADDR_ENA);
    assign w_wr_mode = wr_stb && (addr == c_ADDR_MODE);
    assign w_wr_pend = wr_stb && (addr == c_ADDR_PEND);
    assign w_wr_ctrl = wr_stb && (addr == c_ADDR_CTRL);

    assign w_unused_wrdata = &{1'b0, wrdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_act_prev <= '0;
        end else begin
            r_sync1    <= src;
            r_sync2    <= r_sync1;
            r_act_prev <= w_act;
        end
    end

    assign w_act      = r_sync2 ^ SRC_POL[NUM_SRC-1:0];
    assign w_rise     = w_act & ~r_act_prev;
    assign w_clr      = w_wr_pend ? wrdata[NUM_SRC-1:0] : '0;
    assign w_mode_nxt = w_wr_mode ? wrdata[NUM_SRC-1:0] : r_mode;

    // Edge latches are held at zero while a source is in level mode, so a
    // switch to edge mode starts clear unless an edge lands in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ena       <= '0;
            r_mode      <= '0;
            r_gena      <= 1'b0;
            r_pend_edge <= '0;
        end else begin
            if (w_wr_ena) begin
                r_ena <= wrdata[NUM_SRC-1:0];
            end
            if (w_wr_ctrl) begin
                r_gena <= wrdata[7];
            end
            r_mode      <= w_mode_nxt;
            r_pend_edge <= w_mode_nxt & ((r_pend_edge & ~w_clr) | w_rise);
        end
    end

    assign w_pend = rst ? '0 : ((r_mode & r_pend_edge) | (~r_mode & w_act));
    assign w_hit  = w_pend & r_ena;
    assign w_any  = |w_hit;
    assign w_req  = r_gena & w_any;

    always_comb begin
        w_id = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_id = 3'(i);
            end
        end
    end

    always_comb begin
        w_rd = 8'h00;
        case (addr)
            c_ADDR_ENA:  w_rd[NUM_SRC-1:0] = r_ena;
            c_ADDR_MODE: w_rd[NUM_SRC-1:0] = r_mode;
            c_ADDR_PEND: w_rd[NUM_SRC-1:0] = w_pend;
            c_ADDR_CTRL: w_rd = {r_gena, w_any, 3'b000, w_id};
        endcase
    end

`ifdef ZINT_PULSE_EN
    localparam int c_CNT_MAX = (PULSE_LEN > HOLD_LEN) ? PULSE_LEN : HOLD_LEN;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(PULSE_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = c_CNT_W'(HOLD_LEN - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ASSERT = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;

    // HOLD re-arms straight into ASSERT when the request persists, so the
    // low gap between back-to-back pulses is exactly HOLD_LEN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_int_req <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        r_state   <= c_ST_ASSERT;
                        r_cnt     <= c_PULSE_LOAD;
                        r_int_req <= 1'b1;
                    end
                end
                c_ST_ASSERT: begin
                    if (r_cnt == '0) begin
                        r_state   <= c_ST_HOLD;
                        r_cnt     <= c_HOLD_LOAD;
                        r_int_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt == '0) begin
                        if (w_req) begin
                            r_state   <= c_ST_ASSERT;
                            r_cnt     <= c_PULSE_LOAD;
                            r_int_req <= 1'b1;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_cnt     <= '0;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_req <= 1'b0;
        end else begin
            r_int_req <= w_req;
        end
    end
`endif

    assign rddata  = w_rd;
    assign int_req = r_int_req;
    assign int_id  = w_id;

endmodule
`default_nettype wire

// File: tb/tb_zint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zint_ctrl
//  Brief    : Self-checking bench for zint_ctrl: directed scenarios plus
//             randomized traffic compared against a rule-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zint_ctrl;

    localparam logic [3:0] c_POL = 4'b0001;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] src    = 4'b0001;
    logic       wr_stb = 1'b0;
    logic [1:0] addr   = 2'd0;
    logic [7:0] wrdata = 8'h00;
    logic [7:0] rddata;
    logic       int_req;
    logic [2:0] int_id;

    int n_checks = 0;
    int n_fail   = 0;

    zint_ctrl #(
        .NUM_SRC   (4),
        .SRC_POL   (8'h01),
        .PULSE_LEN (32),
        .HOLD_LEN  (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .src     (src),
        .wr_stb  (wr_stb),
        .addr    (addr),
        .wrdata  (wrdata),
        .rddata  (rddata),
        .int_req (int_req),
        .int_id  (int_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: src history, register values and edge-pending bits.
    logic [3:0] m_d1, m_d2, m_prev, m_pe, m_ena, m_mode;
    logic       m_gena, m_int_req;
    bit         m_live = 1'b0;

    function automatic logic [3:0] m_pend_now();
        m_pend_now = 4'h0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pend_now[i] = m_mode[i] ? m_pe[i] : (m_d2[i] ^ c_POL[i]);
            end
        end
    endfunction

    function automatic logic [2:0] m_id();
        logic [3:0] h;
        logic found;
        m_id  = 3'd0;
        found = 1'b0;
        h     = m_pend_now() & m_ena;
        for (int i = 0; i < 4; i++) begin
            if (h[i] && !found) begin
                m_id  = 3'(i);
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] m_rd(input logic [1:0] a);
        logic [3:0] h;
        h = m_pend_now() & m_ena;
        case (a)
            2'd0:    m_rd = {4'h0, m_ena};
            2'd1:    m_rd = {4'h0, m_mode};
            2'd2:    m_rd = {4'h0, m_pend_now()};
            default: m_rd = {m_gena, (h != 4'h0), 3'b000, m_id()};
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] act, pend, clr, mode_new;
        logic       req;
        if (rst) begin
            m_d1 = 0; m_d2 = 0; m_prev = 0; m_pe = 0;
            m_ena = 0; m_mode = 0; m_gena = 0; m_int_req = 0;
        end else begin
            act      = m_d2 ^ c_POL;
            pend     = m_pend_now();
            req      = m_gena && ((pend & m_ena) != 4'h0);
            mode_new = m_mode;
            clr      = 4'h0;
            if (wr_stb) begin
                case (addr)
                    2'd0: m_ena    = wrdata[3:0];
                    2'd1: mode_new = wrdata[3:0];
                    2'd2: clr      = wrdata[3:0];
                    2'd3: m_gena   = wrdata[7];
                endcase
            end
            for (int i = 0; i < 4; i++) begin
                if (!mode_new[i])                m_pe[i] = 1'b0;
                else if (act[i] && !m_prev[i])   m_pe[i] = 1'b1;
                else if (clr[i])                 m_pe[i] = 1'b0;
            end
            m_mode    = mode_new;
            m_int_req = req;
            m_prev    = act;
            m_d2      = m_d1;
            m_d1      = src;
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
`ifndef ZINT_PULSE_EN
            check("mon_int_req", {7'b0, int_req}, {7'b0, m_int_req});
`endif
            check("mon_int_id", {5'b0, int_id}, {5'b0, m_id()});
            check("mon_rddata", rddata, m_rd(addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        wr_stb = 1'b1; addr = a; wrdata = d;
        tick();
        wr_stb = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, rddata, exp);
    endtask

`ifdef ZINT_PULSE_EN
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (int_req === lvl && n < 500) begin
            tick();
            n++;
        end
    endtask
`endif

    initial begin
        // Reset with toggling sources
        rst = 1'b1;
        tick();
        src = 4'($urandom);
        reg_read("rst_ena", 2'd0, 8'h00);
        reg_read("rst_mode", 2'd1, 8'h00);
        check("rst_int_req", {7'b0, int_req}, 8'h00);
        tick();
        src = 4'($urandom);
        reg_read("rst_pend", 2'd2, 8'h00);
        reg_read("rst_ctrl", 2'd3, 8'h00);
        rst = 1'b0;
        src = 4'b0001;
        repeat (3) tick();

        // Level source 0 (active low)
        reg_write(2'd0, 8'h01);
        reg_write(2'd3, 8'h80);
        src[0] = 1'b0;
        tick(); tick();
`ifndef ZINT_PULSE_EN
        check("lvl_pre", {7'b0, int_req}, 8'h00);
`endif
        tick();
        check("lvl_assert", {7'b0, int_req}, 8'h01);
        reg_read("lvl_ctrl", 2'd3, 8'hC0);
        src[0] = 1'b1;
        tick(); tick();
`ifndef ZINT_PULSE_EN
        check("lvl_hold", {7'b0, int_req}, 8'h01);
        tick();
        check("lvl_release", {7'b0, int_req}, 8'h00);
`endif
        repeat (3) tick();

        // Edge source 1 with W1C
        reg_write(2'd0, 8'h00);
        reg_write(2'd1, 8'h02);
        reg_write(2'd0, 8'h02);
        src[1] = 1'b1;
        tick();
        src[1] = 1'b0;
        repeat (4) tick();
        reg_read("edge_pend", 2'd2, 8'h02);
`ifndef ZINT_PULSE_EN
        repeat (5) tick();
        check("edge_held", {7'b0, int_req}, 8'h01);
`endif
        reg_write(2'd2, 8'h02);
        tick();
`ifndef ZINT_PULSE_EN
        check("edge_w1c_req", {7'b0, int_req}, 8'h00);
`endif
        reg_read("edge_w1c_pend", 2'd2, 8'h00);

        // Set and W1C in the same cycle
        src[1] = 1'b1;
        tick(); tick();
        reg_write(2'd2, 8'h02);
        reg_read("collide_pend", 2'd2, 8'h02);
        src[1] = 1'b0;
        repeat (3) tick();
        reg_write(2'd2, 8'h02);
        reg_read("collide_clr", 2'd2, 8'h00);

        // Priority among edge sources 2 and 3
        reg_write(2'd1, 8'h0C);
        reg_write(2'd0, 8'h0F);
        src[3:2] = 2'b11;
        tick();
        src[3:2] = 2'b00;
        repeat (4) tick();
        reg_read("prio_pend", 2'd2, 8'h0C);
        check("prio_id2", {5'b0, int_id}, 8'h02);
        reg_read("prio_ctrl", 2'd3, 8'hC2);
        reg_write(2'd2, 8'h04);
        check("prio_id3", {5'b0, int_id}, 8'h03);
        reg_read("prio_ctrl3", 2'd3, 8'hC3);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) src = 4'($urandom);
            wr_stb = ($urandom_range(0, 4) == 0);
            addr   = 2'($urandom);
            wrdata = 8'($urandom);
            rst    = ($urandom_range(0, 299) == 0);
            tick();
        end
        wr_stb = 1'b0;
        rst    = 1'b0;

`ifdef ZINT_PULSE_EN
        begin
            int n, h, l;
            rst = 1'b1;
            tick(); tick();
            rst = 1'b0;
            src = 4'b0001;
            repeat (3) tick();
            reg_write(2'd1, 8'h00);
            reg_write(2'd0, 8'h01);
            reg_write(2'd3, 8'h80);
            src[0] = 1'b0;
            n = 0;
            while (int_req !== 1'b1 && n < 20) begin tick(); n++; end
            check("pulse_start", {7'b0, int_req}, 8'h01);
            run_len(1'b1, h);
            check("pulse_high", 8'(h), 8'd32);
            run_len(1'b0, l);
            check("pulse_low", 8'(l), 8'd64);
            run_len(1'b1, h);
            check("pulse_high2", 8'(h), 8'd32);
            n = 0;
            while (int_req !== 1'b1 && n < 100) begin tick(); n++; end
            check("pulse_restart", {7'b0, int_req}, 8'h01);
            repeat (5) tick();
            rst = 1'b1;
            tick();
            check("pulse_rst_abort", {7'b0, int_req}, 8'h00);
            rst = 1'b0;
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
